// File: rtl/pbs_br_loop_sched_pkg.sv
// Shared FSM encoding, width helpers and command record for the BR loop scheduler.
// The command record uses fixed generous field widths; the top truncates to the parameterised port widths.
package pbs_br_loop_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_BSK,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int CMD_LOOP_W = 16;
  localparam int CMD_PID_W  = 8;
  localparam int CMD_POLY_W = 4;
  localparam int CMD_LVL_W  = 4;

  typedef struct packed {
    logic [CMD_LOOP_W-1:0] loop;
    logic [CMD_PID_W-1:0]  pid;
    logic [CMD_POLY_W-1:0] poly;
    logic [CMD_LVL_W-1:0]  lvl;
    logic                  first;
    logic                  last;
  } br_cmd_t;

  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic int loop_width(input int lwe_k);
    return clog2_min1(lwe_k);
  endfunction

  function automatic int poly_width(input int glwe_k);
    return clog2_min1(glwe_k + 1);
  endfunction

  function automatic int lvl_width(input int pbs_l);
    return clog2_min1(pbs_l);
  endfunction

  function automatic int idx_width(input int batch_max);
    return clog2_min1(batch_max);
  endfunction

endpackage

// File: rtl/pbs_br_cmd_cnt.sv
// Nested lvl/poly/pid-index counter walking the external-product commands of one iteration.
// Wraps to all-zero after the last command so the next iteration starts clean.
module pbs_br_cmd_cnt
  import pbs_br_loop_sched_pkg::*;
#(
  parameter int GLWE_K    = 1,
  parameter int PBS_L     = 1,
  parameter int BATCH_MAX = 8,
  localparam int IDX_W    = idx_width(BATCH_MAX),
  localparam int POLY_W   = poly_width(GLWE_K),
  localparam int LVL_W    = lvl_width(PBS_L)
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic              clr,
  input  logic              en,
  input  logic [IDX_W-1:0]  pid_max,
  output logic [IDX_W-1:0]  pid_idx,
  output logic [POLY_W-1:0] poly,
  output logic [LVL_W-1:0]  lvl,
  output logic              first,
  output logic              last
);

  logic [IDX_W-1:0]  idx_reg;
  logic [POLY_W-1:0] poly_reg;
  logic [LVL_W-1:0]  lvl_reg;
  logic              lvl_last;
  logic              poly_last;
  logic              idx_last;

  assign lvl_last  = (lvl_reg == LVL_W'(PBS_L - 1));
  assign poly_last = (poly_reg == POLY_W'(GLWE_K));
  assign idx_last  = (idx_reg == pid_max);

  always_ff @(posedge clk) begin
    if (s_rst || clr) begin
      idx_reg  <= '0;
      poly_reg <= '0;
      lvl_reg  <= '0;
    end else if (en) begin
      if (lvl_last) begin
        lvl_reg <= '0;
        if (poly_last) begin
          poly_reg <= '0;
          idx_reg  <= idx_last ? '0 : idx_reg + 1'b1;
        end else begin
          poly_reg <= poly_reg + 1'b1;
        end
      end else begin
        lvl_reg <= lvl_reg + 1'b1;
      end
    end
  end

  assign pid_idx = idx_reg;
  assign poly    = poly_reg;
  assign lvl     = lvl_reg;
  assign first   = (idx_reg == '0) && (poly_reg == '0) && (lvl_reg == '0);
  assign last    = idx_last && poly_last && lvl_last;

endmodule

// File: rtl/pbs_br_loop_sched.sv
// Blind-rotation loop scheduler: per iteration, one BSK slice request followed by one
// external-product command per (pid, poly, lvl), throttled by a loop-credit counter.
module pbs_br_loop_sched
  import pbs_br_loop_sched_pkg::*;
#(
  parameter int LWE_K        = 839,
  parameter int GLWE_K       = 1,
  parameter int PBS_L        = 1,
  parameter int BATCH_MAX    = 8,
  parameter int PID_W        = 5,
  parameter int MAX_INFLIGHT = 2,
  localparam int LOOP_W      = loop_width(LWE_K),
  localparam int POLY_W      = poly_width(GLWE_K),
  localparam int LVL_W       = lvl_width(PBS_L),
  localparam int CNT_W       = $clog2(BATCH_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       s_rst,
  input  logic                       batch_vld,
  output logic                       batch_rdy,
  input  logic [CNT_W-1:0]           batch_cnt,
  input  logic [BATCH_MAX*PID_W-1:0] batch_pid,
  output logic                       bsk_req_vld,
  input  logic                       bsk_req_rdy,
  output logic [LOOP_W-1:0]          bsk_req_loop,
  output logic                       cmd_vld,
  input  logic                       cmd_rdy,
  output logic [LOOP_W-1:0]          cmd_loop,
  output logic [PID_W-1:0]           cmd_pid,
  output logic [POLY_W-1:0]          cmd_poly,
  output logic [LVL_W-1:0]           cmd_lvl,
  output logic                       cmd_first,
  output logic                       cmd_last,
  input  logic                       loop_done,
  output logic                       batch_done,
  output logic                       busy,
  output logic                       err_underflow
);

  localparam int IDX_W = idx_width(BATCH_MAX);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

  state_t                         state_reg;
  logic [LOOP_W-1:0]              loop_reg;
  logic [IDX_W-1:0]               pid_max_reg;
  logic [IDX_W-1:0]               pid_max_next;
  logic [BATCH_MAX-1:0][PID_W-1:0] pid_list_reg;
  logic [INF_W-1:0]               inflight_reg;
  logic                           err_reg;
  logic                           batch_rdy_reg;
  logic                           bsk_vld_reg;
  logic                           cmd_vld_reg;
  logic                           busy_reg;
  logic                           done_reg;
  br_cmd_t                        cmd_reg;
  br_cmd_t                        cmd_next;

  logic                           batch_take;
  logic                           bsk_take;
  logic                           cmd_take;
  logic                           last_take;
  logic                           cmd_load;

  logic [IDX_W-1:0]               cnt_idx;
  logic [POLY_W-1:0]              cnt_poly;
  logic [LVL_W-1:0]               cnt_lvl;
  logic                           cnt_first;
  logic                           cnt_last;
  logic                           unused_cmd_bits;

  assign batch_take = (state_reg == ST_IDLE) && batch_rdy_reg && batch_vld;
  assign bsk_take   = bsk_vld_reg && bsk_req_rdy;
  assign cmd_take   = cmd_vld_reg && cmd_rdy;
  assign last_take  = cmd_take && cmd_reg.last;
  // The counter always points at the command to be loaded next into cmd_reg.
  assign cmd_load   = bsk_take || (cmd_take && !cmd_reg.last);

  // A count of 0 is treated as 1; anything above BATCH_MAX is clamped.
  always_comb begin
    pid_max_next = '0;
    if (batch_cnt > CNT_W'(BATCH_MAX)) begin
      pid_max_next = IDX_W'(BATCH_MAX - 1);
    end else if (batch_cnt != '0) begin
      pid_max_next = IDX_W'(batch_cnt - 1'b1);
    end
  end

  pbs_br_cmd_cnt #(
    .GLWE_K    (GLWE_K),
    .PBS_L     (PBS_L),
    .BATCH_MAX (BATCH_MAX)
  ) u_cmd_cnt (
    .clk     (clk),
    .s_rst   (s_rst),
    .clr     (batch_take),
    .en      (cmd_load),
    .pid_max (pid_max_reg),
    .pid_idx (cnt_idx),
    .poly    (cnt_poly),
    .lvl     (cnt_lvl),
    .first   (cnt_first),
    .last    (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (batch_take) begin
      pid_list_reg <= batch_pid;
    end
  end

  always_comb begin
    cmd_next       = '0;
    cmd_next.loop  = CMD_LOOP_W'(loop_reg);
    cmd_next.pid   = CMD_PID_W'(pid_list_reg[cnt_idx]);
    cmd_next.poly  = CMD_POLY_W'(cnt_poly);
    cmd_next.lvl   = CMD_LVL_W'(cnt_lvl);
    cmd_next.first = cnt_first;
    cmd_next.last  = cnt_last;
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      cmd_reg <= '0;
    end else if (cmd_load) begin
      cmd_reg <= cmd_next;
    end
  end

  // Simultaneous issue and retire cancel; a retire with no credit outstanding is flagged.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      inflight_reg <= '0;
      err_reg      <= 1'b0;
    end else if (last_take && !loop_done) begin
      inflight_reg <= inflight_reg + 1'b1;
    end else if (loop_done && !last_take) begin
      if (inflight_reg == '0) begin
        err_reg <= 1'b1;
      end else begin
        inflight_reg <= inflight_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_reg     <= ST_IDLE;
      loop_reg      <= '0;
      pid_max_reg   <= '0;
      batch_rdy_reg <= 1'b0;
      bsk_vld_reg   <= 1'b0;
      cmd_vld_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          batch_rdy_reg <= 1'b1;
          if (batch_take) begin
            batch_rdy_reg <= 1'b0;
            busy_reg      <= 1'b1;
            loop_reg      <= '0;
            pid_max_reg   <= pid_max_next;
            state_reg     <= ST_CREDIT;
          end
        end
        ST_CREDIT: begin
          if (inflight_reg < INF_W'(MAX_INFLIGHT)) begin
            bsk_vld_reg <= 1'b1;
            state_reg   <= ST_BSK;
          end
        end
        ST_BSK: begin
          if (bsk_take) begin
            bsk_vld_reg <= 1'b0;
            cmd_vld_reg <= 1'b1;
            state_reg   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (last_take) begin
            cmd_vld_reg <= 1'b0;
            if (loop_reg == LOOP_W'(LWE_K - 1)) begin
              state_reg <= ST_DRAIN;
            end else begin
              loop_reg  <= loop_reg + 1'b1;
              state_reg <= ST_CREDIT;
            end
          end
        end
        ST_DRAIN: begin
          if (inflight_reg == '0) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_reg      <= 1'b0;
          batch_rdy_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign batch_rdy       = batch_rdy_reg;
  assign bsk_req_vld     = bsk_vld_reg;
  assign bsk_req_loop    = loop_reg;
  assign cmd_vld         = cmd_vld_reg;
  assign cmd_loop        = cmd_reg.loop[LOOP_W-1:0];
  assign cmd_pid         = cmd_reg.pid[PID_W-1:0];
  assign cmd_poly        = cmd_reg.poly[POLY_W-1:0];
  assign cmd_lvl         = cmd_reg.lvl[LVL_W-1:0];
  assign cmd_first       = cmd_reg.first;
  assign cmd_last        = cmd_reg.last;
  assign batch_done      = done_reg;
  assign busy            = busy_reg;
  assign err_underflow   = err_reg;
  assign unused_cmd_bits = ^cmd_reg;

endmodule

// File: tb/tb_pbs_br_loop_sched.sv
// Directed bench: a small LWE_K=4 instance for protocol/credit/reset scenarios and a
// default-parameter instance for the full-length randomly stalled command stream.
`timescale 1ns/1ps
module tb_pbs_br_loop_sched;

  localparam int PID_W     = 5;
  localparam int BATCH_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic                       rst_s, rst_b, vld_s, vld_b;
  logic                       bsk_rdy, cmd_rdy, man_ld_s, auto_ld_s, auto_ld_b;
  logic [3:0]                 cnt;
  logic [BATCH_MAX*PID_W-1:0] pids;
  logic [2:0]                 pipe_s = '0;
  logic [2:0]                 pipe_b = '0;
  logic                       ld_s, ld_b;

  logic       s_batch_rdy, s_bsk_vld, s_cmd_vld, s_cmd_first, s_cmd_last, s_done, s_busy, s_err;
  logic [1:0] s_bsk_loop, s_cmd_loop;
  logic [4:0] s_cmd_pid;
  logic       s_cmd_poly, s_cmd_lvl;
  logic [18:0] s_all;

  logic       b_batch_rdy, b_bsk_vld, b_cmd_vld, b_cmd_first, b_cmd_last, b_done, b_busy, b_err;
  logic [9:0] b_bsk_loop, b_cmd_loop;
  logic [4:0] b_cmd_pid;
  logic       b_cmd_poly, b_cmd_lvl;
  logic [18:0] b_fields;

  assign ld_s     = (auto_ld_s & pipe_s[2]) | man_ld_s;
  assign ld_b     = auto_ld_b & pipe_b[2];
  assign s_all    = {s_batch_rdy, s_bsk_vld, s_bsk_loop, s_cmd_vld, s_cmd_loop, s_cmd_pid,
                     s_cmd_poly, s_cmd_lvl, s_cmd_first, s_cmd_last, s_done, s_busy, s_err};
  assign b_fields = {b_cmd_loop, b_cmd_pid, b_cmd_poly, b_cmd_lvl, b_cmd_first, b_cmd_last};

  // loop_done model: retire each iteration 3 cycles after its last command is accepted.
  always @(posedge clk) begin
    pipe_s <= {pipe_s[1:0], s_cmd_vld & cmd_rdy & s_cmd_last};
    pipe_b <= {pipe_b[1:0], b_cmd_vld & cmd_rdy & b_cmd_last};
  end

  pbs_br_loop_sched #(.LWE_K(4)) dut_s (
    .clk(clk), .s_rst(rst_s), .batch_vld(vld_s), .batch_rdy(s_batch_rdy),
    .batch_cnt(cnt), .batch_pid(pids), .bsk_req_vld(s_bsk_vld), .bsk_req_rdy(bsk_rdy),
    .bsk_req_loop(s_bsk_loop), .cmd_vld(s_cmd_vld), .cmd_rdy(cmd_rdy), .cmd_loop(s_cmd_loop),
    .cmd_pid(s_cmd_pid), .cmd_poly(s_cmd_poly), .cmd_lvl(s_cmd_lvl), .cmd_first(s_cmd_first),
    .cmd_last(s_cmd_last), .loop_done(ld_s), .batch_done(s_done), .busy(s_busy),
    .err_underflow(s_err)
  );

  pbs_br_loop_sched dut_b (
    .clk(clk), .s_rst(rst_b), .batch_vld(vld_b), .batch_rdy(b_batch_rdy),
    .batch_cnt(cnt), .batch_pid(pids), .bsk_req_vld(b_bsk_vld), .bsk_req_rdy(bsk_rdy),
    .bsk_req_loop(b_bsk_loop), .cmd_vld(b_cmd_vld), .cmd_rdy(cmd_rdy), .cmd_loop(b_cmd_loop),
    .cmd_pid(b_cmd_pid), .cmd_poly(b_cmd_poly), .cmd_lvl(b_cmd_lvl), .cmd_first(b_cmd_first),
    .cmd_last(b_cmd_last), .loop_done(ld_b), .batch_done(b_done), .busy(b_busy),
    .err_underflow(b_err)
  );

  task automatic test_reset();
    rst_s = 1'b1; rst_b = 1'b1; vld_s = 1'b0; vld_b = 1'b0; bsk_rdy = 1'b0; cmd_rdy = 1'b0;
    man_ld_s = 1'b0; auto_ld_s = 1'b0; auto_ld_b = 1'b0; cnt = 4'd0; pids = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (s_all !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want all zero", s_all);
    end
    rst_s = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_batch_rdy !== 1'b1 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: batch_rdy=%b busy=%b want 1 0", s_batch_rdy, s_busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int n_bsk = 0, n_cmd = 0, n_done = 0;
    logic [10:0] exp_c;
    cmd_rdy = 1'b1; bsk_rdy = 1'b1; auto_ld_s = 1'b1;
    cnt = 4'd1; pids = '0; pids[4:0] = 5'd3;
    vld_s = 1'b1;
    @(negedge clk);
    vld_s = 1'b0;
    vectors++;
    if (s_bsk_vld !== 1'b0 || s_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_credit_cycle: bsk_vld=%b busy=%b want 0 1", s_bsk_vld, s_busy);
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) begin
        vectors++;
        if (s_bsk_vld !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_handshake_bsk: bsk_vld=%b want 1", s_bsk_vld);
        end
      end
      if (s_bsk_vld && bsk_rdy) begin
        vectors++;
        if (s_bsk_loop !== 2'(n_bsk)) begin
          miscompares++;
          $display("FAIL basic_bsk_loop: got %0d want %0d", s_bsk_loop, n_bsk);
        end
        n_bsk++;
      end
      if (s_cmd_vld && cmd_rdy) begin
        exp_c = {2'(n_cmd / 2), 5'd3, 1'(n_cmd % 2), 1'b0, (n_cmd % 2) == 0, (n_cmd % 2) == 1};
        vectors++;
        if ({s_cmd_loop, s_cmd_pid, s_cmd_poly, s_cmd_lvl, s_cmd_first, s_cmd_last} !== exp_c) begin
          miscompares++;
          $display("FAIL basic_cmd[%0d]: got %b want %b", n_cmd,
                   {s_cmd_loop, s_cmd_pid, s_cmd_poly, s_cmd_lvl, s_cmd_first, s_cmd_last}, exp_c);
        end
        n_cmd++;
      end
      if (s_done) n_done++;
    end
    vectors++;
    if (n_bsk != 4 || n_cmd != 8 || n_done != 1) begin
      miscompares++;
      $display("FAIL basic_totals: bsk=%0d cmd=%0d done=%0d want 4 8 1", n_bsk, n_cmd, n_done);
    end
    vectors++;
    if (s_busy !== 1'b0 || s_batch_rdy !== 1'b1 || s_err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle_after: busy=%b rdy=%b err=%b want 0 1 0", s_busy, s_batch_rdy, s_err);
    end
    auto_ld_s = 1'b0;
    $display("test_basic: %0d bsk, %0d cmds, %0d batch_done", n_bsk, n_cmd, n_done);
  endtask

  task automatic test_credit();
    int n_last = 0;
    logic saw_bsk = 1'b0;
    cmd_rdy = 1'b1; bsk_rdy = 1'b1; auto_ld_s = 1'b0; cnt = 4'd1;
    vld_s = 1'b1;
    @(negedge clk);
    vld_s = 1'b0;
    for (int c = 0; c < 40 && n_last < 2; c++) begin
      @(negedge clk);
      if (s_cmd_vld && cmd_rdy && s_cmd_last) n_last++;
    end
    vectors++;
    if (n_last != 2) begin
      miscompares++;
      $display("FAIL credit_two_loops: got %0d loops want 2", n_last);
    end
    repeat (10) begin
      @(negedge clk);
      if (s_bsk_vld) saw_bsk = 1'b1;
    end
    vectors++;
    if (saw_bsk !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_stall: bsk_vld seen=%b want 0", saw_bsk);
    end
    man_ld_s = 1'b1;
    @(negedge clk);
    man_ld_s = 1'b0;
    vectors++;
    if (s_bsk_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_release_early: bsk_vld=%b want 0", s_bsk_vld);
    end
    @(negedge clk);
    vectors++;
    if (s_bsk_vld !== 1'b1 || s_bsk_loop !== 2'd2) begin
      miscompares++;
      $display("FAIL credit_release: bsk_vld=%b loop=%0d want 1 2", s_bsk_vld, s_bsk_loop);
    end
    $display("test_credit: stalled after %0d loops, released loop 2", n_last);
  endtask

  task automatic test_mid_reset();
    int n_done = 0;
    cmd_rdy = 1'b0;
    for (int c = 0; c < 10 && !s_cmd_vld; c++) @(negedge clk);
    vectors++;
    if (s_cmd_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_reach_issue: cmd_vld=%b want 1 (timeout)", s_cmd_vld);
    end
    rst_s = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_all !== 19'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs: got %b want all zero", s_all);
    end
    rst_s = 1'b0; cmd_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_batch_rdy !== 1'b1 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_release: rdy=%b busy=%b want 1 0", s_batch_rdy, s_busy);
    end
    repeat (20) begin
      @(negedge clk);
      if (s_done) n_done++;
    end
    vectors++;
    if (n_done != 0 || s_cmd_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_no_done: done=%0d cmd_vld=%b want 0 0", n_done, s_cmd_vld);
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_underflow();
    int n_last = 0;
    man_ld_s = 1'b1;
    @(negedge clk);
    man_ld_s = 1'b0;
    vectors++;
    if (s_err !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_flag: err=%b want 1", s_err);
    end
    cnt = 4'd1; cmd_rdy = 1'b1; bsk_rdy = 1'b1;
    vld_s = 1'b1;
    @(negedge clk);
    vld_s = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_cmd_vld && cmd_rdy && s_cmd_last) n_last++;
    end
    vectors++;
    if (n_last != 2 || s_err !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_credit: loops=%0d err=%b want 2 1", n_last, s_err);
    end
    $display("test_underflow: %0d loops issued after underflow", n_last);
  endtask

  task automatic test_simultaneous();
    int n_last = 0, n_cmd = 0;
    logic [4:0] exp_pid;
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    cnt = 4'd2; pids = '0; pids[4:0] = 5'd7; pids[9:5] = 5'd21;
    cmd_rdy = 1'b1; bsk_rdy = 1'b1;
    vld_s = 1'b1;
    @(negedge clk);
    vld_s = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      man_ld_s = s_cmd_vld && cmd_rdy && s_cmd_last && (s_cmd_loop == 2'd1);
      if (s_cmd_vld && cmd_rdy) begin
        exp_pid = (((n_cmd % 4) / 2) == 0) ? 5'd7 : 5'd21;
        vectors++;
        if (s_cmd_pid !== exp_pid) begin
          miscompares++;
          $display("FAIL simul_pid[%0d]: got %0d want %0d", n_cmd, s_cmd_pid, exp_pid);
        end
        n_cmd++;
        if (s_cmd_last) n_last++;
      end
    end
    man_ld_s = 1'b0;
    vectors++;
    if (n_last != 3 || s_err !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_inflight: loops=%0d err=%b want 3 0", n_last, s_err);
    end
    $display("test_simultaneous: %0d loops, %0d cmds", n_last, n_cmd);
  endtask

  task automatic test_big_random();
    int n_cmd = 0, n_bsk = 0, n_done = 0, k = 0, loop_i = 0;
    logic prev_stall = 1'b0;
    logic [18:0] prev_fields = '0;
    logic [18:0] exp_f;
    logic [4:0] ep;
    for (int i = 0; i < BATCH_MAX; i++) pids[i*PID_W +: PID_W] = 5'((i * 3 + 5) % 32);
    cnt = 4'd8; bsk_rdy = 1'b1; auto_ld_b = 1'b1;
    rst_b = 1'b0;
    @(negedge clk);
    vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    for (int c = 0; c < 60000 && n_done == 0; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        vectors++;
        if (b_fields !== prev_fields) begin
          miscompares++;
          $display("FAIL big_stall_hold: got %b want %b", b_fields, prev_fields);
        end
      end
      if (b_bsk_vld && bsk_rdy) begin
        vectors++;
        if (b_bsk_loop !== 10'(n_bsk)) begin
          miscompares++;
          $display("FAIL big_bsk_loop: got %0d want %0d", b_bsk_loop, n_bsk);
        end
        n_bsk++;
      end
      if (b_done) n_done++;
      cmd_rdy = 1'($urandom_range(0, 1));
      if (b_cmd_vld && cmd_rdy) begin
        ep = pids[(k / 2) * PID_W +: PID_W];
        exp_f = {10'(loop_i), ep, 1'(k % 2), 1'b0, k == 0, k == 15};
        vectors++;
        if (b_fields !== exp_f) begin
          miscompares++;
          $display("FAIL big_cmd[%0d]: got %b want %b", n_cmd, b_fields, exp_f);
        end
        n_cmd++;
        k++;
        if (k == 16) begin
          k = 0;
          loop_i++;
        end
      end
      prev_stall  = b_cmd_vld && !cmd_rdy;
      prev_fields = b_fields;
    end
    vectors++;
    if (n_cmd != 13424 || n_bsk != 839 || n_done != 1 || b_err !== 1'b0) begin
      miscompares++;
      $display("FAIL big_totals: cmd=%0d bsk=%0d done=%0d err=%b want 13424 839 1 0",
               n_cmd, n_bsk, n_done, b_err);
    end
    cmd_rdy = 1'b1;
    $display("test_big_random: %0d cmds, %0d bsk", n_cmd, n_bsk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_mid_reset();
    test_underflow();
    test_simultaneous();
    test_big_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pbs_br_loop_sched.md
# pbs_br_loop_sched

Blind-rotation loop scheduler for the PBS pipeline. It accepts a batch of ciphertext PIDs and walks the LWE_K blind-rotation iterations. Each iteration requests the matching BSK slice, then issues one external-product command per (PID, GLWE polynomial, decomposition level) to the BR datapath. A loop-credit counter bounds the number of iterations in flight ahead of the accumulator.

## Interface
- LWE_K, 839: number of BR iterations; tied to the global TFHE parameter set at integration.
- GLWE_K, 1: GLWE dimension; GLWE_K+1 polynomials are issued per PID.
- PBS_L, 1: decomposition levels.
- BATCH_MAX, 8: maximum PIDs per batch.
- PID_W, 5: PID width.
- MAX_INFLIGHT, 2: maximum issued-but-unretired loops.

Ports:
- clk  in  1  clock
- s_rst  in  1  synchronous reset, active-high
- batch_vld  in  1  batch offer
- batch_rdy  out  1  batch accept
- batch_cnt  in  $clog2(BATCH_MAX+1)  PID count, 1..BATCH_MAX
- batch_pid  in  BATCH_MAX*PID_W  PID list; entry i is at [i*PID_W +: PID_W]
- bsk_req_vld  out  1  BSK slice request
- bsk_req_rdy  in  1  request accept
- bsk_req_loop  out  LOOP_W  iteration index
- cmd_vld  out  1  command valid
- cmd_rdy  in  1  command accept
- cmd_loop  out  LOOP_W  iteration
- cmd_pid  out  PID_W  PID
- cmd_poly  out  POLY_W  polynomial 0..GLWE_K
- cmd_lvl  out  LVL_W  level 0..PBS_L-1
- cmd_first  out  1  first command of the iteration
- cmd_last  out  1  last command of the iteration
- loop_done  in  1  one-cycle pulse when one iteration retires
- batch_done  out  1  one-cycle pulse when the batch is complete
- busy  out  1  high whenever the FSM is not in IDLE
- err_underflow  out  1  sticky; set by loop_done while the credit counter is 0

## Operation
- FSM states: IDLE, CREDIT, BSK, ISSUE, DRAIN, DONE.
- IDLE: batch_rdy=1. On batch_vld, capture batch_cnt and batch_pid, clear loop=0, go to CREDIT. A batch_cnt of 0 is illegal and is treated as 1.
- CREDIT: go to BSK when inflight<MAX_INFLIGHT; otherwise hold.
- BSK: bsk_req_vld=1 with bsk_req_loop=loop. On bsk_req_rdy, go to ISSUE.
- ISSUE: cmd_vld=1. Counter order, fastest first: lvl, then poly, then pid index. Commands per loop = batch_cnt*(GLWE_K+1)*PBS_L.
  - cmd_first=1 when all counters are 0.
  - cmd_last=1 when pid index=batch_cnt-1, poly=GLWE_K and lvl=PBS_L-1.
  - On accepting the last command: increment inflight and clear the counters. If loop=LWE_K-1, go to DRAIN; otherwise increment loop and go to CREDIT.
- DRAIN: go to DONE when inflight==0.
- DONE: batch_done=1 for one cycle, then IDLE.
- inflight update per cycle: +1 on last-command accept, -1 on loop_done. When both occur in the same cycle, the value is unchanged.
- loop_done with inflight==0: inflight stays 0 and err_underflow is set. err_underflow is cleared only by s_rst.

## Timing
- Reset values:
  - all outputs 0 during reset, including batch_rdy and err_underflow;
  - FSM=IDLE, inflight=0;
  - batch_rdy=1 in the first cycle after reset deasserts.
- Batch handshake to bsk_req_vld: 2 cycles (CREDIT then BSK) when credit is available.
- Command stream sustains 1 command/cycle with cmd_rdy=1. Fields are registered and held stable while cmd_vld && !cmd_rdy.
- Minimum gap between iterations: accept of last command, then CREDIT and BSK cycles. This gives ≥2 idle command cycles, plus the bsk_req_rdy wait.
- batch_done asserts 1 cycle after inflight reaches 0 in DRAIN.
- Reset mid-batch: all state is abandoned on the next edge, no batch_done is produced, and the outputs match the reset values.
- Counter widths:
  - LOOP_W=$clog2(LWE_K)
  - POLY_W=$clog2(GLWE_K+1), minimum 1
  - LVL_W=$clog2(PBS_L), minimum 1
  - inflight is $clog2(MAX_INFLIGHT+1) bits.

## Structure
- Package pbs_br_loop_sched_pkg holds:
  - the state enum;
  - the width localparam functions;
  - a packed struct br_cmd_t {loop, pid, poly, lvl, first, last}.
- Sub-module pbs_br_cmd_cnt: a nested lvl/poly/pid counter with an enable input, a last flag and synchronous clear, instantiated once.

## Test plan
- LWE_K=4, GLWE_K=1, PBS_L=1, batch_cnt=1, pid=3, with all ready signals high and loop_done 3 cycles after each last command -> 4 BSK requests (loops 0..3) and 8 commands with pid 3 and poly alternating 0,1. Exactly one batch_done.
- loop_done withheld -> after loops 0 and 1 are issued, bsk_req_vld stays 0. One loop_done pulse -> bsk_req_vld for loop 2 rises 2 cycles later.
- Defaults, batch_cnt=8, cmd_rdy 50% random -> 839*16=13424 commands in order, and no field changes while stalled.
- inflight=1 with last-command accept and loop_done in the same cycle -> inflight stays 1. loop_done at inflight=0 -> err_underflow=1 and inflight stays 0.
- s_rst asserted mid-ISSUE -> all outputs are 0 next cycle, batch_rdy=1 after release, and no batch_done is produced.
